// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_cmd_decoder: SPI byte stream to framed register-file read/write bus.   |
// | Define SPI_CMD_AUTOINC_EN for per-access reg_addr increment. Rev 1.0       |
// +----------------------------------------------------------------------------+
module spi_cmd_decoder #(
   parameter int MAX_LEN = 127
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       frame_done,
   output logic       frame_err
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
`ifdef SPI_CMD_AUTOINC_EN
   localparam logic [7:0] ADDR_INC = 8'd1;
`else
   localparam logic [7:0] ADDR_INC = 8'd0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_WDATA  = 3'd2,
      S_RFETCH = 3'd3,
      S_RWAIT  = 3'd4,
      S_RSEND  = 3'd5,
      S_FLUSH  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic             is_rd_q, is_rd_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             pending_q, pending_d;
   logic             ovr_seen_q, ovr_seen_d;
   logic [7:0]       reg_addr_q, reg_addr_d;
   logic [7:0]       reg_wdata_q, reg_wdata_d;
   logic             reg_wr_q, reg_wr_d;
   logic             reg_rd_q, reg_rd_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             tx_load_q, tx_load_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         is_rd_q      <= 1'b0;
         remaining_q  <= '0;
         pending_q    <= 1'b0;
         ovr_seen_q   <= 1'b0;
         reg_addr_q   <= 8'h00;
         reg_wdata_q  <= 8'h00;
         reg_wr_q     <= 1'b0;
         reg_rd_q     <= 1'b0;
         tx_byte_q    <= 8'h00;
         tx_load_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         is_rd_q      <= is_rd_d;
         remaining_q  <= remaining_d;
         pending_q    <= pending_d;
         ovr_seen_q   <= ovr_seen_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         reg_wr_q     <= reg_wr_d;
         reg_rd_q     <= reg_rd_d;
         tx_byte_q    <= tx_byte_d;
         tx_load_q    <= tx_load_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      is_rd_d      = is_rd_q;
      remaining_d  = remaining_q;
      pending_d    = pending_q;
      ovr_seen_d   = ovr_seen_q;
      reg_wdata_d  = reg_wdata_q;
      tx_byte_d    = tx_byte_q;
      reg_wr_d     = 1'b0;
      reg_rd_d     = 1'b0;
      tx_load_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      // The address steps in the cycle after the write strobe so it is stable during it.
      reg_addr_d   = reg_wr_q ? reg_addr_q + ADDR_INC : reg_addr_q;

      if (cs && state_q != S_IDLE && state_q != S_FLUSH) begin
         frame_err_d = 1'b1;
         pending_d   = 1'b0;
         state_d     = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_valid && !cs) begin
                  is_rd_d     = rx_data[7];
                  remaining_d = LEN_W'(rx_data[6:0]);
                  pending_d   = 1'b0;
                  ovr_seen_d  = 1'b0;
                  state_d     = S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  reg_addr_d = rx_data;
                  if (remaining_q == '0) begin
                     frame_done_d = 1'b1;
                     state_d      = S_FLUSH;
                  end else if (is_rd_q) begin
                     reg_rd_d = 1'b1;
                     state_d  = S_RFETCH;
                  end else begin
                     state_d = S_WDATA;
                  end
               end
            end
            S_WDATA: begin
               if (rx_valid) begin
                  reg_wdata_d = rx_data;
                  reg_wr_d    = 1'b1;
                  remaining_d = remaining_q - LEN_W'(1);
                  if (remaining_q == LEN_W'(1)) begin
                     frame_done_d = 1'b1;
                     state_d      = S_FLUSH;
                  end
               end
            end
            S_RFETCH: begin
               if (rx_valid) pending_d = 1'b1;
               state_d = S_RWAIT;
            end
            S_RWAIT: begin
               if (rx_valid) pending_d = 1'b1;
               tx_byte_d  = reg_rdata;
               tx_load_d  = 1'b1;
               reg_addr_d = reg_addr_q + ADDR_INC;
               state_d    = S_RSEND;
            end
            S_RSEND: begin
               // A held dummy and a fresh one can coincide; the fresh one stays pending.
               if (pending_q || rx_valid) begin
                  pending_d   = pending_q && rx_valid;
                  remaining_d = remaining_q - LEN_W'(1);
                  if (remaining_q == LEN_W'(1)) begin
                     pending_d    = 1'b0;
                     frame_done_d = 1'b1;
                     state_d      = S_FLUSH;
                  end else begin
                     reg_rd_d = 1'b1;
                     state_d  = S_RFETCH;
                  end
               end
            end
            S_FLUSH: begin
               if (cs) begin
                  state_d = S_IDLE;
               end else if (rx_valid && !ovr_seen_q) begin
                  frame_err_d = 1'b1;
                  ovr_seen_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign tx_byte    = tx_byte_q;
   assign tx_load    = tx_load_q;
   assign reg_addr   = reg_addr_q;
   assign reg_wdata  = reg_wdata_q;
   assign reg_wr     = reg_wr_q;
   assign reg_rd     = reg_rd_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_cmd_decoder: randomized SPI frames against a frame-level model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_cmd_decoder;
`ifdef SPI_CMD_AUTOINC_EN
   localparam int INC = 1;
`else
   localparam int INC = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] reg_rdata = 8'h00;
   logic [7:0] tx_byte, reg_addr, reg_wdata;
   logic       tx_load, reg_wr, reg_rd, frame_done, frame_err;

   always #5 clk = ~clk;

   spi_cmd_decoder #(.MAX_LEN(127)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_byte(tx_byte), .tx_load(tx_load), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   // Registered RAM on the shared bus
   logic [7:0] ram [256];
   logic       ram_clr = 1'b0;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
      end else begin
         if (reg_wr) ram[reg_addr] <= reg_wdata;
         if (reg_rd) reg_rdata <= ram[reg_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
   typedef struct packed { logic done; logic err; logic [7:0] rd; } frame_t;

   wr_t        exp_wr [$];
   logic [7:0] exp_tx [$];
   frame_t     exp_fr [$];
   logic [7:0] ref_mem [256];

   int   last_rx_cyc = 0;
   logic chk_tim = 1'b1;
   logic end_pulse = 1'b0;
   logic rst_chk = 1'b0;

   // Monitor / scoreboard
   int     checks = 0, errors = 0;
   int     done_cnt = 0, err_cnt = 0, rd_cnt = 0;
   wr_t    mw;
   frame_t mf;
   logic [7:0] mt;

   always @(negedge clk) begin
      if (rst_chk) begin
         checks++;
         if ({tx_byte, tx_load, reg_addr, reg_wdata, reg_wr, reg_rd, frame_done, frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs tx_byte=%02h tx_load=%b addr=%02h wdata=%02h wr=%b rd=%b done=%b err=%b expected all 0",
                     tx_byte, tx_load, reg_addr, reg_wdata, reg_wr, reg_rd, frame_done, frame_err);
         end
      end
      if (reg_wr) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL reg_wr unexpected addr=%02h data=%02h expected no write", reg_addr, reg_wdata);
         end else begin
            mw = exp_wr.pop_front();
            if (mw.a !== reg_addr || mw.d !== reg_wdata) begin
               errors++;
               $display("FAIL reg_wr got addr=%02h data=%02h expected addr=%02h data=%02h",
                        reg_addr, reg_wdata, mw.a, mw.d);
            end
         end
         checks++;
         if (cyc - last_rx_cyc != 1) begin
            errors++;
            $display("FAIL wr_latency got %0d expected 1", cyc - last_rx_cyc);
         end
      end
      if (reg_rd) rd_cnt++;
      if (tx_load) begin
         checks++;
         if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_load unexpected byte=%02h expected no load", tx_byte);
         end else begin
            mt = exp_tx.pop_front();
            if (mt !== tx_byte) begin
               errors++;
               $display("FAIL tx_byte got %02h expected %02h", tx_byte, mt);
            end
         end
         if (chk_tim) begin
            checks++;
            if (cyc - last_rx_cyc != 3) begin
               errors++;
               $display("FAIL tx_latency got %0d expected 3", cyc - last_rx_cyc);
            end
         end
      end
      if (frame_done || frame_err) begin
         checks++;
         if (frame_done && frame_err) begin
            errors++;
            $display("FAIL done_err_same_cycle got done=1 err=1 expected one at most");
         end
      end
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
      if (end_pulse) begin
         checks++;
         if (exp_fr.size() == 0) begin
            errors++;
            $display("FAIL frame_end no expectation queued");
         end else begin
            mf = exp_fr.pop_front();
            if (done_cnt != int'(mf.done) || err_cnt != int'(mf.err) || rd_cnt != int'(mf.rd) ||
                exp_wr.size() != 0 || exp_tx.size() != 0) begin
               errors++;
               $display("FAIL frame_end got done=%0d err=%0d rd=%0d wr_left=%0d tx_left=%0d expected done=%0d err=%0d rd=%0d wr_left=0 tx_left=0",
                        done_cnt, err_cnt, rd_cnt, exp_wr.size(), exp_tx.size(), mf.done, mf.err, mf.rd);
            end
         end
         exp_wr.delete();
         exp_tx.delete();
         done_cnt = 0;
         err_cnt  = 0;
         rd_cnt   = 0;
      end
   end

   // Stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data     = b;
      rx_valid    = 1'b1;
      last_rx_cyc = cyc;
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic close_frame(input frame_t f);
      exp_fr.push_back(f);
      repeat (3) tick();
      end_pulse = 1'b1;
      tick();
      end_pulse = 1'b0;
   endtask

   // Frame-level reference: what a frame of these bytes, cut after nsend bytes, must do.
   task automatic run_frame(input logic [7:0] fb[$], input int nsend, input int gmin, input int gmax);
      int n, ndata, acc;
      logic rd, done, err;
      logic [7:0] a;
      frame_t f;
      n     = int'(fb[0][6:0]);
      rd    = fb[0][7];
      ndata = (nsend >= 2) ? nsend - 2 : 0;
      done  = 1'b0;
      err   = 1'b0;
      acc   = 0;
      if (nsend == 1) begin
         err = 1'b1;
      end else if (nsend >= 2 && ndata < n) begin
         err = 1'b1;
         acc = rd ? ndata + 1 : ndata;
      end else if (nsend >= 2) begin
         done = 1'b1;
         err  = (ndata > n);
         acc  = n;
      end
      for (int i = 0; i < acc; i++) begin
         a = 8'((int'(fb[1]) + i * INC) % 256);
         if (rd) exp_tx.push_back(ref_mem[a]);
         else begin
            exp_wr.push_back('{a: a, d: fb[2 + i]});
            ref_mem[a] = fb[2 + i];
         end
      end
      f = '{done: done, err: err, rd: rd ? 8'(acc) : 8'd0};
      cs = 1'b0;
      tick();
      for (int i = 0; i < nsend; i++) send_byte(fb[i], $urandom_range(gmax, gmin));
      repeat (3) tick();
      cs = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
      end
      tick();
      rx_valid = 1'b0;
      close_frame(f);
   endtask

   initial begin
      logic [7:0] q[$];
      int n, extra, nsend;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
      ram_clr = 1'b1;
      repeat (2) tick();
      rst_chk = 1'b1;
      tick();
      rst_chk = 1'b0;
      ram_clr = 1'b0;
      rst_n   = 1'b1;
      tick();

      q = '{8'h02, 8'h10, 8'hAA, 8'hBB};  run_frame(q, 4, 3, 5);
      q = '{8'h82, 8'h10, 8'h00, 8'h00};  run_frame(q, 4, 3, 5);
      q = '{8'h02, 8'hFF, 8'h11, 8'h22};  run_frame(q, 4, 3, 5);
      q = '{8'h82, 8'hFF, 8'h5A, 8'hA5};  run_frame(q, 4, 3, 5);
      q = '{8'h03, 8'h20, 8'h55};         run_frame(q, 3, 3, 5);
      q = '{8'h01, 8'h30, 8'h66, 8'h77};  run_frame(q, 4, 3, 5);

      // Reset in the middle of a write burst: only the strobes already issued count.
      exp_wr.push_back('{a: 8'h50, d: 8'hC1});
      exp_wr.push_back('{a: 8'(8'h50 + INC), d: 8'hC2});
      ref_mem[8'h50] = 8'hC1;
      ref_mem[8'(8'h50 + INC)] = 8'hC2;
      cs = 1'b0;
      tick();
      send_byte(8'h04, 3);
      send_byte(8'h50, 3);
      send_byte(8'hC1, 3);
      send_byte(8'hC2, 1);
      rst_n = 1'b0;
      tick();
      rst_chk = 1'b1;
      tick();
      rst_chk = 1'b0;
      cs      = 1'b1;
      rst_n   = 1'b1;
      tick();
      close_frame('{done: 1'b0, err: 1'b0, rd: 8'd0});
      q = '{8'h00, 8'h40};                run_frame(q, 2, 3, 5);

      // Dummies arriving during fetch are held and consumed later.
      chk_tim = 1'b0;
      q = '{8'h82, 8'h10, 8'h00, 8'h00};  run_frame(q, 4, 1, 1);
      chk_tim = 1'b1;

      for (int t = 0; t < 60; t++) begin
         n = $urandom_range(5, 0);
         q = {};
         q.push_back({1'($urandom_range(1, 0)), 7'(n)});
         q.push_back(($urandom_range(3, 0) == 0) ? 8'($urandom_range(8'hFF, 8'hFD)) : 8'($urandom));
         extra = 0;
         nsend = n + 2;
         case ($urandom_range(3, 0))
            2: extra = $urandom_range(2, 1);
            3: nsend = $urandom_range(n + 1, 0);
            default: ;
         endcase
         for (int i = 0; i < n + extra; i++) q.push_back(8'($urandom));
         if (extra != 0) nsend = n + 2 + extra;
         run_frame(q, nsend, 3, 5);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Byte-level command decoder that sits directly downstream of `spi_slave`. It consumes received SPI bytes, parses them into framed read/write commands, and drives the shared 8-bit register-file bus (`reg_addr`/`reg_wdata`/`reg_wr`/`reg_rd`/`reg_rdata`) used by the I2C path. It also produces transmit bytes for `spi_slave` on reads. This gives the SPI link the same register access the I2C slave already has.

## Interface
- `MAX_LEN`, 127: maximum burst length; the length field is 7 bits.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cs`  in  1  SPI chip select, active-low, already synchronised to `clk`. High ends or aborts the frame.
- `rx_data`  in  8  received byte from `spi_slave`.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_byte`  out  8  next byte for `spi_slave` to shift out on MISO.
- `tx_load`  out  1  one-cycle strobe; `tx_byte` is updated in this cycle.
- `reg_addr`  out  8  register-file address.
- `reg_wdata`  out  8  register-file write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  register-file read data, valid 1 cycle after `reg_rd` (registered RAM).
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `frame_err`  out  1  one-cycle pulse on abort or overrun.

## Operation
- Frame format:
  - Byte 0 is CMD: bit7 = 1 for read, 0 for write; bits[6:0] = N, the data byte count.
  - Byte 1 is ADDR.
  - Then N data bytes (write) or N dummy bytes (read).
- States: IDLE, ADDR, WDATA, RFETCH, RWAIT, RSEND, FLUSH.
- IDLE:
  - `rx_valid` with `cs` low latches the CMD fields and the 7-bit `remaining` = N, then goes to ADDR.
- ADDR:
  - `rx_valid` latches `reg_addr`.
  - N = 0: pulse `frame_done`, go to FLUSH.
  - Write: go to WDATA.
  - Read: go to RFETCH.
- WDATA:
  - Each `rx_valid` registers `reg_wdata` = `rx_data` and pulses `reg_wr`.
  - Then increment `reg_addr` (8-bit, wraps 0xFF→0x00) and decrement `remaining`.
  - When `remaining` reaches 0: pulse `frame_done`, go to FLUSH.
- RFETCH: pulse `reg_rd`, then go to RWAIT.
- RWAIT: one cycle for RAM latency, then go to RSEND.
- RSEND:
  - Set `tx_byte` = `reg_rdata`, pulse `tx_load`, increment `reg_addr`, then wait for a dummy byte.
  - Each dummy `rx_valid` decrements `remaining`.
  - If `remaining` is still > 0, go to RFETCH.
  - Otherwise pulse `frame_done` and go to FLUSH.
- Pending dummy byte: if a dummy `rx_valid` arrives during RFETCH or RWAIT, it is held in a one-deep pending flag and consumed on entry to RSEND, after `tx_load`.
- FLUSH:
  - Further `rx_valid` bytes are ignored; the first one pulses `frame_err` (overrun).
  - `cs` high returns the block to IDLE.
- `cs` high in any state other than IDLE or FLUSH:
  - Pulse `frame_err` and go to IDLE.
  - No further `reg_wr`/`reg_rd` is issued; writes already done are kept.
- `rx_valid` while `cs` is high is ignored.

## Timing
- Reset: all outputs are 0, `tx_byte` = 0x00, state = IDLE, pending flag cleared. Reset applies at any point, including mid-frame, and issues no further bus strobes.
- Write: `reg_wr` is high in cycle T+1 for a data `rx_valid` in cycle T, with `reg_addr`/`reg_wdata` stable in that cycle.
- Read:
  - ADDR `rx_valid` at cycle T gives `reg_rd` at T+1 and `tx_load` at T+3.
  - Each dummy `rx_valid` at cycle T gives the next `tx_load` at T+3 (or later, if a pending byte was queued).
- `frame_done`/`frame_err` pulse one cycle after the causing event and never both in the same cycle.
- Simultaneous `cs` rising and `rx_valid` in the same cycle: `cs` wins and the byte is discarded.

## Configuration
- `SPI_CMD_AUTOINC_EN` defined: `reg_addr` increments after each access, as described above.
- `SPI_CMD_AUTOINC_EN` undefined: `reg_addr` stays fixed for the whole burst, giving FIFO-port semantics; all other behaviour is identical.

## Test plan
- Write 0x02,0x10,0xAA,0xBB → two `reg_wr` pulses; mem[0x10]=0xAA, mem[0x11]=0xBB; one `frame_done`.
- Preload mem[0x10]=0xAA, mem[0x11]=0xBB, then send read 0x82,0x10,dummy,dummy → `tx_load` carries 0xAA then 0xBB; `reg_rd` pulses exactly 2 times; `tx_load` lands 3 cycles after the ADDR strobe.
- Write 0x02,0xFF,0x11,0x22 → mem[0xFF]=0x11, mem[0x00]=0x22 (wrap). With the macro undefined: mem[0xFF]=0x22.
- Send 0x03,0x20,0x55, then raise `cs` → one write to 0x20, `frame_err` pulse, no `frame_done`; the next frame decodes normally.
- Write 0x01,0x30,0x66,0x77 → one `reg_wr` only (0x66 to 0x30), `frame_done` then `frame_err` on the extra byte.
- Assert `rst_n` low in WDATA mid-burst → outputs cleared next cycle, no strobes; a subsequent frame 0x00,0x40 gives `frame_done` with no bus access.
